imem_uart_loader: RTL and testbench
===================================

IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning UART bit rate; DIV = CLK_HZ/BAUD, truncated, minimum 4.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rxd, input, 1 bit: asynchronous UART serial input, idle high.
REQ-006 SHALL have port load_en, input, 1 bit: loading permitted; CPU clock is held while high.
REQ-007 SHALL have port we, output, 1 bit: instruction-memory write strobe, one cycle wide.
REQ-008 SHALL have port waddr, output, 6 bits: instruction-memory word address.
REQ-009 SHALL have port wdata, output, 32 bits: instruction word to write.
REQ-010 SHALL have port busy, output, 1 bit: high when the FSM is in LEN or DATA.
REQ-011 SHALL have port done, output, 1 bit: sticky, high after a complete load.
REQ-012 SHALL have port frame_err, output, 1 bit: sticky, high after a stop-bit error or abort during a load.
REQ-013 SHALL have port word_cnt, output, 7 bits: number of words written in the current load.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer; the receiver uses only the synchronized value.
REQ-015 Receiver SHALL use 8N1 framing, LSB first.
REQ-016 Receiver start bit: a high-to-low transition of the synchronized rxd starts a DIV/2 count; if rxd is high at that point, it is a false start and the receiver returns to idle.
REQ-017 Receiver sampling: data bits 0..7 SHALL be sampled every DIV cycles after the start midpoint; the stop bit is sampled DIV cycles after bit 7.
REQ-018 SHALL issue an internal byte_valid pulse, one cycle wide, with the byte when the stop bit samples 1; a stop bit of 0 SHALL discard the byte and pulse byte_err.
REQ-019 Loader FSM states SHALL be IDLE, LEN, DATA, FIN.
REQ-020 IDLE: byte 0xA5 goes to LEN, clears done, frame_err, word_cnt and waddr; all other bytes are ignored.
REQ-021 LEN: the received byte sets N = byte[6:0]; the value 0 and any value >64 SHALL be treated as 64; the FSM then goes to DATA.
REQ-022 DATA: bytes assemble little-endian (first byte = wdata[7:0]); on the 4th byte_valid, we SHALL pulse in the next cycle with the assembled wdata and the current waddr.
REQ-023 After each write, waddr and word_cnt SHALL increment in the cycle after we; the write of word N SHALL move the FSM to FIN.
REQ-024 FIN: done=1 for one cycle of state, then IDLE; done stays high until the next 0xA5 or reset.
REQ-025 A byte_err in LEN or DATA SHALL set frame_err and go to IDLE with no further we; a byte_err in IDLE SHALL be ignored.
REQ-026 load_en low SHALL force the FSM to IDLE next cycle and suppress we; if the FSM was in LEN or DATA, frame_err SHALL be set. The receiver keeps running, but its bytes are dropped.
REQ-027 A partially assembled word SHALL be discarded on any return to IDLE.
REQ-028 we SHALL never be high in two consecutive cycles; waddr SHALL never exceed 63.

Reset
REQ-029 On rstn low, the following SHALL reset asynchronously: we=0, waddr=0, wdata=0, busy=0, done=0, frame_err=0, word_cnt=0, FSM=IDLE, receiver idle, synchronizer flops=1.
REQ-030 Reset asserted mid-byte or mid-load SHALL abort without any write; after release, the first valid start bit begins a fresh byte.

Verification (CLK_HZ=16, BAUD=1, DIV=16)
REQ-031 Scenario, normal load: load_en=1; send A5 02 13 00 00 00 B3 00 50 00 -> we at waddr 0 with wdata 0x00000013, then we at waddr 1 with wdata 0x005000B3, word_cnt=2, done=1, busy=0.
REQ-032 Scenario, stop-bit error: send A5 01 then a byte with stop bit 0 -> frame_err=1, no we, FSM in IDLE; a following A5 clears frame_err.
REQ-033 Scenario, false start: 4-cycle low glitch on rxd -> no byte_valid, FSM state unchanged.
REQ-034 Scenario, length 0: send A5 00 plus 256 data bytes -> 64 we pulses at waddr 0..63, word_cnt=64, done=1.
REQ-035 Scenario, abort: drop load_en after 2 of 4 data bytes -> frame_err=1, no we; bytes sent afterwards are ignored.
REQ-036 Scenario, reset mid-load: rstn low during word 1 -> all outputs return to reset values; a new load from A5 then completes normally.

Source files
------------

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART (8N1) boot loader for a 64-word instruction memory.
// Frame: 0xA5 header, one length byte (0 or >64 means 64 words), then the
// words as little-endian byte quadruples. Each completed word is written
// with a one-cycle we strobe at consecutive word addresses.
module imem_uart_loader #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rxd,
    input  logic        load_en,
    output logic        we,
    output logic [5:0]  waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        frame_err,
    output logic [6:0]  word_cnt
);

    localparam int DIV_RAW = CLK_HZ / BAUD;
    localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
    localparam int CW      = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((DIV / 2) - 1);
    localparam logic [7:0]    HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA, ST_FIN} ld_state_t;

    // Length byte decode: only bits [6:0] count; 0 and anything above 64 mean 64.
    function automatic logic [6:0] decode_len(input logic [7:0] b);
        logic [6:0] n;
        if ((b[6:0] == 7'd0) || (b[6:0] > 7'd64)) begin
            n = 7'd64;
        end else begin
            n = b[6:0];
        end
        return n;
    endfunction

    // ---------------- receiver ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            byte_err_q, byte_err_d;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver bit-timing: half-bit start check, then one sample per bit period.
    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        byte_valid_d = 1'b0;
        byte_err_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shift_q;
                    end else begin
                        byte_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
                cnt_d      = '0;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'd0;
            rx_byte_q    <= 8'd0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            byte_valid_q <= byte_valid_d;
            byte_err_q   <= byte_err_d;
        end
    end

    // ---------------- loader ----------------
    ld_state_t   state_q, state_d;
    logic [6:0]  n_q, n_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] wdata_q, wdata_d;
    logic [5:0]  waddr_q, waddr_d;
    logic [6:0]  word_cnt_q, word_cnt_d;
    logic        we_q, we_d;
    logic        done_q, done_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;

    // Loader next-state: header/length parsing, word assembly, write strobe, abort handling.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        word_cnt_d  = word_cnt_q;
        we_d        = 1'b0;
        done_d      = done_q;
        frame_err_d = frame_err_q;

        // Address/count advance in the cycle after each strobe; address holds at 63.
        if (we_q) begin
            word_cnt_d = word_cnt_q + 7'd1;
            if (waddr_q != 6'd63) begin
                waddr_d = waddr_q + 6'd1;
            end else begin
                waddr_d = waddr_q;
            end
        end else begin
            word_cnt_d = word_cnt_q;
        end

        if (!load_en) begin
            if ((state_q == ST_LEN) || (state_q == ST_DATA)) begin
                frame_err_d = 1'b1;
            end else begin
                frame_err_d = frame_err_q;
            end
            state_d    = ST_IDLE;
            byte_idx_d = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_valid_q && (rx_byte_q == HDR_BYTE)) begin
                        state_d     = ST_LEN;
                        done_d      = 1'b0;
                        frame_err_d = 1'b0;
                        word_cnt_d  = 7'd0;
                        waddr_d     = 6'd0;
                        byte_idx_d  = 2'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LEN: begin
                    if (byte_err_q) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (byte_valid_q) begin
                        n_d        = decode_len(rx_byte_q);
                        byte_idx_d = 2'd0;
                        state_d    = ST_DATA;
                    end else begin
                        state_d = ST_LEN;
                    end
                end
                ST_DATA: begin
                    if (byte_err_q) begin
                        frame_err_d = 1'b1;
                        byte_idx_d  = 2'd0;
                        state_d     = ST_IDLE;
                    end else if (byte_valid_q) begin
                        case (byte_idx_q)
                            2'd0:    asm_d[7:0]   = rx_byte_q;
                            2'd1:    asm_d[15:8]  = rx_byte_q;
                            2'd2:    asm_d[23:16] = rx_byte_q;
                            default: begin
                                wdata_d = {rx_byte_q, asm_q};
                                we_d    = 1'b1;
                            end
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end else if (we_q && ((word_cnt_q + 7'd1) == n_q)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_FIN: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_LEN) || (state_d == ST_DATA);
    end

    // Loader state and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            n_q         <= 7'd64;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'd0;
            wdata_q     <= 32'd0;
            waddr_q     <= 6'd0;
            word_cnt_q  <= 7'd0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            word_cnt_q  <= word_cnt_d;
            we_q        <= we_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Testbench for imem_uart_loader: UART byte driver, reference model of the
// load protocol feeding an expected-write queue, and a write monitor.
module tb_imem_uart_loader;

    logic        clk;
    logic        rstn;
    logic        rxd;
    logic        load_en;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        frame_err;
    logic [6:0]  word_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [37:0] exp_q[$];
    logic        prev_we = 1'b0;

    imem_uart_loader #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .load_en(load_en),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
        .done(done), .frame_err(frame_err), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is compared against the oldest expected write.
    always @(negedge clk) begin
        if (rstn && we) begin
            check("we_not_back_to_back", {63'd0, prev_we}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_we_addr_data", {26'd0, waddr, wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("we_waddr", {58'd0, waddr}, {58'd0, e[37:32]});
                check("we_wdata", {32'd0, wdata}, {32'd0, e[31:0]});
            end
        end
        prev_we = we;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame, 16 clocks per bit; stop_ok=0 sends a low stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(16);
        end
        rxd = stop_ok;
        wait_cycles(16);
        rxd = 1'b1;
        wait_cycles(2);
    endtask

    // Reference model: number of words a length byte asks for.
    function automatic int model_len(input logic [7:0] b);
        int n;
        n = int'(b[6:0]);
        if (n == 0 || n > 64) n = 64;
        return n;
    endfunction

    // Complete load: builds random payload, queues model writes, sends, checks end state.
    task automatic full_load(input logic [7:0] len_b, input string tag);
        int n;
        logic [7:0] pay[$];
        n = model_len(len_b);
        for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom_range(0, 255)));
        for (int k = 0; k < n; k++)
            exp_q.push_back({6'(k), pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]});
        send_byte(8'hA5, 1'b1);
        send_byte(len_b, 1'b1);
        foreach (pay[i]) send_byte(pay[i], 1'b1);
        wait_cycles(20);
        check({tag, "_done"},      {63'd0, done},      64'd1);
        check({tag, "_busy"},      {63'd0, busy},      64'd0);
        check({tag, "_frame_err"}, {63'd0, frame_err}, 64'd0);
        check({tag, "_word_cnt"},  {57'd0, word_cnt},  64'(n));
        check({tag, "_all_written"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},        {63'd0, we},        64'd0);
        check({tag, "_waddr"},     {58'd0, waddr},     64'd0);
        check({tag, "_wdata"},     {32'd0, wdata},     64'd0);
        check({tag, "_busy"},      {63'd0, busy},      64'd0);
        check({tag, "_done"},      {63'd0, done},      64'd0);
        check({tag, "_frame_err"}, {63'd0, frame_err}, 64'd0);
        check({tag, "_word_cnt"},  {57'd0, word_cnt},  64'd0);
    endtask

    initial begin
        logic [7:0] b [4];
        logic [7:0] d;
        rstn = 1'b0;
        rxd = 1'b1;
        load_en = 1'b1;
        wait_cycles(5);
        check_reset_vals("reset");
        rstn = 1'b1;
        wait_cycles(5);

        // Normal two-word load with fixed bytes.
        exp_q.push_back({6'd0, 32'h0000_0013});
        exp_q.push_back({6'd1, 32'h0050_00B3});
        send_byte(8'hA5, 1'b1);
        wait_cycles(4);
        check("hdr_busy", {63'd0, busy}, 64'd1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hB3, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h50, 1'b1); send_byte(8'h00, 1'b1);
        wait_cycles(20);
        check("normal_done", {63'd0, done}, 64'd1);
        check("normal_busy", {63'd0, busy}, 64'd0);
        check("normal_word_cnt", {57'd0, word_cnt}, 64'd2);
        check("normal_all_written", 64'(exp_q.size()), 64'd0);

        // False start: short glitch while three bytes of a word are pending.
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
        send_byte(8'hA5, 1'b1);
        wait_cycles(4);
        check("a5_clears_done", {63'd0, done}, 64'd0);
        send_byte(8'h01, 1'b1);
        send_byte(b[0], 1'b1); send_byte(b[1], 1'b1); send_byte(b[2], 1'b1);
        rxd = 1'b0;
        wait_cycles(4);
        rxd = 1'b1;
        wait_cycles(40);
        check("glitch_busy", {63'd0, busy}, 64'd1);
        check("glitch_no_write", {57'd0, word_cnt}, 64'd0);
        exp_q.push_back({6'd0, b[3], b[2], b[1], b[0]});
        send_byte(b[3], 1'b1);
        wait_cycles(20);
        check("glitch_load_done", {63'd0, done}, 64'd1);
        check("glitch_all_written", 64'(exp_q.size()), 64'd0);

        // Stop-bit error inside the data phase, then a fresh header clears it.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        wait_cycles(20);
        check("stoperr_frame_err", {63'd0, frame_err}, 64'd1);
        check("stoperr_busy", {63'd0, busy}, 64'd0);
        send_byte(8'hA5, 1'b1);
        wait_cycles(4);
        check("a5_clears_frame_err", {63'd0, frame_err}, 64'd0);
        check("a5_after_err_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
        exp_q.push_back({6'd0, b[3], b[2], b[1], b[0]});
        send_byte(8'h01, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(b[i], 1'b1);
        wait_cycles(20);
        check("recover_done", {63'd0, done}, 64'd1);
        check("recover_word_cnt", {57'd0, word_cnt}, 64'd1);

        // Random short loads; bit 7 of the length byte is don't-care.
        full_load({1'($urandom_range(0, 1)), 7'($urandom_range(1, 3))}, "rand1");
        full_load({1'($urandom_range(0, 1)), 7'($urandom_range(1, 3))}, "rand2");

        // Abort: load_en drops after two data bytes.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        load_en = 1'b0;
        wait_cycles(3);
        check("abort_frame_err", {63'd0, frame_err}, 64'd1);
        check("abort_busy", {63'd0, busy}, 64'd0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        wait_cycles(4);
        check("abort_ignored_busy", {63'd0, busy}, 64'd0);
        load_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom_range(0, 255));
            if (d == 8'hA5) d = 8'h5A;
            send_byte(d, 1'b1);
        end
        wait_cycles(4);
        check("abort_after_busy", {63'd0, busy}, 64'd0);
        check("abort_after_frame_err", {63'd0, frame_err}, 64'd1);
        check("abort_word_cnt", {57'd0, word_cnt}, 64'd0);

        // Length byte 0 means a full 64-word load.
        full_load(8'h00, "len0");

        // Reset in the middle of a byte of word 1.
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
        exp_q.push_back({6'd0, b[3], b[2], b[1], b[0]});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(b[i], 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        rxd = 1'b0;
        wait_cycles(40);
        rstn = 1'b0;
        rxd = 1'b1;
        wait_cycles(3);
        check_reset_vals("midreset");
        check("midreset_word0_written", 64'(exp_q.size()), 64'd0);
        rstn = 1'b1;
        wait_cycles(5);
        full_load({1'b0, 7'($urandom_range(1, 3))}, "postreset");

        wait_cycles(10);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
